fifo_frame_rx: RTL and testbench
================================

# fifo_frame_rx

Read-domain frame parser that sits directly downstream of the async FIFO's read port. It pops bytes from the FIFO and hunts for a sync byte. It validates the length and checksum of each frame and forwards the payload as a valid/ready stream with start/end markers and an error flag on the final beat. It also keeps good-frame, error and dropped-byte counters for status registers.

## Interface
- DATA_WIDTH, 8, byte width; must match the FIFO data width.
- SYNC_BYTE, 8'hA5, frame delimiter.
- MAX_LEN, 64, maximum payload length in bytes, range 1..2**DATA_WIDTH-1.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk_read  in  1  read-domain clock; the block runs on this clock only.
- rst_n  in  1  reset, synchronous and active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO head word; valid whenever fifo_empty=0.
- fifo_read  out  1  pop strobe; only ever high when fifo_empty=0.
- m_data  out  DATA_WIDTH  payload byte.
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream accept.
- m_sop  out  1  first payload byte of a frame.
- m_eop  out  1  last payload byte of a frame.
- m_err  out  1  qualifies the eop beat: checksum mismatch.
- len_err  out  1  one-cycle pulse: a LEN byte was rejected.
- frame_count  out  CNT_WIDTH  good frames delivered, wraps.
- err_count  out  CNT_WIDTH  length plus checksum errors, wraps.
- drop_count  out  CNT_WIDTH  bytes discarded while hunting, wraps.

## Operation
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK, where CHK = LEN XOR all payload bytes.
- FIFO contract:
  - fifo_data shows the head while not empty.
  - A pop in cycle t exposes the next head in cycle t+1.
  - fifo_read is combinational from state, fifo_empty and m_ready.
- HUNT:
  - Pop whenever not empty.
  - If the byte equals SYNC_BYTE, go to LEN; otherwise increment drop_count.
- LEN:
  - Pop whenever not empty.
  - LEN of 0 or greater than MAX_LEN: pulse len_err, increment err_count, go to HUNT.
  - Otherwise load remaining=LEN and chk=LEN, set first=1, go to PAYLOAD.
- PAYLOAD:
  - Pop only when !fifo_empty && (!m_valid || m_ready).
  - On each pop: m_data<=byte, m_sop<=first, m_eop<=0, chk^=byte, remaining decrements, first<=0.
  - m_valid<=1 unless remaining==1. The last byte is latched but held invalid; go to CHK.
- CHK:
  - m_valid is 0 here. Pop when not empty.
  - On the pop: m_valid<=1, m_eop<=1, m_err<=(byte!=chk), m_sop keeps its value (LEN=1 gives sop and eop on the same beat).
  - If chk matches, increment frame_count; otherwise increment err_count. Go to HUNT.
- Output register: when m_valid && m_ready and no new load in that cycle, m_valid<=0.
- HUNT and LEN pop regardless of m_ready. The pending eop beat holds stable until accepted.
- m_data, m_sop, m_eop and m_err stay stable while m_valid && !m_ready.

## Timing
- Reset (rst_n low at a clk_read edge):
  - state=HUNT.
  - m_valid, m_sop, m_eop, m_err, len_err and fifo_read are 0.
  - All counters are 0; m_data=0.
  - Reset mid-frame abandons the frame without an eop beat.
- Throughput: 1 byte/cycle when the FIFO is non-empty and m_ready=1.
- A frame of N payload bytes uses N+3 pop cycles.
- Latency: payload byte popped at edge t is valid on m_data after edge t. The eop beat is valid after the CHK pop edge.
- fifo_empty asserting mid-frame stalls the FSM in place; no timeout.
- Counters wrap modulo 2**CNT_WIDTH. A good frame increments frame_count at the CHK pop edge, before eop is accepted.

## Structure
- Shared package fifo_frame_pkg holds:
  - the state encoding (HUNT, LEN, PAYLOAD, CHK), 2 bits;
  - the default SYNC_BYTE;
  - the frame field order constants.
- Single module; no sub-module is warranted. The checksum accumulator and output register are inline.

## Test plan
- FIFO holds A5 03 11 22 33 (03^11^22^33), m_ready=1:
  - 11(sop), 22, 33(eop, err=0) are delivered;
  - frame_count=1, drop_count=0.
- Bytes 00 7F A5 01 5A 5B:
  - drop_count=2;
  - a single beat 5A with sop=1, eop=1, err=0.
- A5 03 11 22 33 FF (bad CHK):
  - eop beat 33 with m_err=1;
  - err_count=1, frame_count=0.
- A5 00 and A5 41 with MAX_LEN=64:
  - len_err pulses twice; err_count=2;
  - the following valid frame parses correctly.
- Backpressure with m_ready low for 5 cycles mid-payload:
  - m_data stays stable;
  - no extra fifo_read beyond the one byte already latched;
  - the stream order is intact.
- rst_n low for 1 cycle after the LEN pop of a frame:
  - all outputs and counters return to 0;
  - the remaining payload bytes count as drop_count until the next A5.

Source files
------------

// File: rtl/fifo_frame_pkg.sv
// Shared definitions for the FIFO read-side frame parser.
// Holds the parser state encoding, the default frame delimiter and the
// positions of the fixed frame fields: SYNC, LEN, payload..., CHK.
package fifo_frame_pkg;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHK     = 2'd3
   } state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Field order within a frame. The payload occupies LEN bytes starting at
   // FIELD_PAYLOAD. The checksum follows the last payload byte.
   localparam int FIELD_SYNC     = 0;
   localparam int FIELD_LEN      = 1;
   localparam int FIELD_PAYLOAD  = 2;
   localparam int FRAME_OVERHEAD = 3;   // sync + len + chk

endpackage

// File: rtl/fifo_frame_rx.sv
// fifo_frame_rx: read-domain frame parser sitting on an async FIFO read port.
// It pops bytes and hunts for SYNC_BYTE. It checks LEN and the XOR checksum,
// and streams the payload out on a valid/ready interface with sop/eop/err
// markers. It also keeps wrap-around status counters.
//
// Ports
//   clk_read     read-domain clock
//   rst_n        synchronous active-low reset
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO head word (valid while !fifo_empty)
//   fifo_read    pop strobe (combinational, never high while empty)
//   m_data       payload byte
//   m_valid      beat valid
//   m_ready      downstream accept
//   m_sop        first payload byte of a frame
//   m_eop        last payload byte of a frame
//   m_err        checksum mismatch, qualifies the eop beat
//   len_err      one-cycle pulse, LEN byte rejected
//   frame_count  good frames delivered
//   err_count    length + checksum errors
//   drop_count   bytes discarded while hunting
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_HUNT    | discard bytes until SYNC_BYTE is popped
// ST_LEN     | pop and validate the length byte
// ST_PAYLOAD | pop payload bytes into the output register as it frees up
// ST_CHK     | pop checksum, release the held last byte as the eop beat
module fifo_frame_rx
   import fifo_frame_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = DATA_WIDTH'(DEFAULT_SYNC_BYTE),
   parameter int                    MAX_LEN    = 64,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk_read,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_read,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sop,
   output logic                  m_eop,
   output logic                  m_err,
   output logic                  len_err,
   output logic [CNT_WIDTH-1:0]  frame_count,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [CNT_WIDTH-1:0]  drop_count
);

   localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);
   localparam logic [DATA_WIDTH-1:0] ONE_W     = DATA_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] remaining;
   logic [DATA_WIDTH-1:0] chk;
   logic                  first;
   logic                  pop;
   logic                  is_sync;
   logic                  len_bad;
   logic                  last_payload;
   logic                  chk_match;

   assign is_sync      = (fifo_data == SYNC_BYTE);
   assign len_bad      = (fifo_data == '0) || (fifo_data > MAX_LEN_W);
   assign last_payload = (remaining == ONE_W);
   assign chk_match    = (fifo_data == chk);
   assign fifo_read    = pop;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         ST_HUNT: begin
            pop = !fifo_empty;
            if (pop && is_sync) begin
               state_nxt = ST_LEN;
            end
         end
         ST_LEN: begin
            pop = !fifo_empty;
            if (pop) begin
               state_nxt = len_bad ? ST_HUNT : ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            // Only pop when the output register is free or being drained.
            pop = !fifo_empty && (!m_valid || m_ready);
            if (pop && last_payload) begin
               state_nxt = ST_CHK;
            end
         end
         ST_CHK: begin
            pop = !fifo_empty;
            if (pop) begin
               state_nxt = ST_HUNT;
            end
         end
         default: begin
            state_nxt = ST_HUNT;
         end
      endcase
      // No pop while reset is held, so nothing popped in a reset cycle is lost.
      if (!rst_n) begin
         pop = 1'b0;
      end
   end

   always_ff @(posedge clk_read) begin
      if (!rst_n) begin
         state       <= ST_HUNT;
         remaining   <= '0;
         chk         <= '0;
         first       <= 1'b0;
         m_data      <= '0;
         m_valid     <= 1'b0;
         m_sop       <= 1'b0;
         m_eop       <= 1'b0;
         m_err       <= 1'b0;
         len_err     <= 1'b0;
         frame_count <= '0;
         err_count   <= '0;
         drop_count  <= '0;
      end else begin
         state   <= state_nxt;
         len_err <= 1'b0;

         // Drain an accepted beat. A load below in the same cycle overrides this.
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end

         case (state)
            ST_HUNT: begin
               if (pop && !is_sync) begin
                  drop_count <= drop_count + CNT_ONE;
               end
            end
            ST_LEN: begin
               if (pop) begin
                  if (len_bad) begin
                     len_err   <= 1'b1;
                     err_count <= err_count + CNT_ONE;
                  end else begin
                     remaining <= fifo_data;
                     chk       <= fifo_data;
                     first     <= 1'b1;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (pop) begin
                  m_data    <= fifo_data;
                  m_sop     <= first;
                  m_eop     <= 1'b0;
                  m_err     <= 1'b0;
                  chk       <= chk ^ fifo_data;
                  remaining <= remaining - ONE_W;
                  first     <= 1'b0;
                  // The last payload byte is parked invalid until its checksum
                  // arrives so that eop and err can be presented with it.
                  m_valid   <= !last_payload;
               end
            end
            ST_CHK: begin
               if (pop) begin
                  m_valid <= 1'b1;
                  m_eop   <= 1'b1;
                  m_err   <= !chk_match;
                  if (chk_match) begin
                     frame_count <= frame_count + CNT_ONE;
                  end else begin
                     err_count <= err_count + CNT_ONE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_frame_rx.sv
// Self-checking bench for fifo_frame_rx. A queue stands in for the FIFO.
// A frame-level reference model consumes every popped byte and predicts the
// delivered beats, the counters and the len_err pulse. These are compared on
// every cycle. Directed scenarios add hand-computed literal expectations.
module tb_fifo_frame_rx;
   import fifo_frame_pkg::*;

   localparam int MAXL = 64;

   logic        clk_read = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_data = 8'h00;
   logic        fifo_read;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        m_sop;
   logic        m_eop;
   logic        m_err;
   logic        len_err;
   logic [15:0] frame_count;
   logic [15:0] err_count;
   logic [15:0] drop_count;

   always #5 clk_read = ~clk_read;

   fifo_frame_rx #(
      .DATA_WIDTH (8),
      .SYNC_BYTE  (8'hA5),
      .MAX_LEN    (MAXL),
      .CNT_WIDTH  (16)
   ) dut (
      .clk_read    (clk_read),
      .rst_n       (rst_n),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_read   (fifo_read),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_sop       (m_sop),
      .m_eop       (m_eop),
      .m_err       (m_err),
      .len_err     (len_err),
      .frame_count (frame_count),
      .err_count   (err_count),
      .drop_count  (drop_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  fq[$];
   bit          hold_empty = 1'b0;

   // reference model state
   bit          mdl_hunting = 1'b1;
   logic [7:0]  mdl_buf[$];
   logic [15:0] mdl_frames = '0;
   logic [15:0] mdl_errs = '0;
   logic [15:0] mdl_drops = '0;
   bit          mdl_len_err = 1'b0;
   logic [10:0] exp_beats[$];     // {err, eop, sop, data}
   logic [10:0] got_beats[$];

   int          pop_total = 0;
   int          len_err_seen = 0;
   bit          prev_hold = 1'b0;
   logic [10:0] prev_beat = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void drive_fifo();
      fifo_empty = hold_empty || (fq.size() == 0);
      fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
   endfunction

   function automatic void model_reset();
      mdl_hunting = 1'b1;
      mdl_buf.delete();
      mdl_frames  = '0;
      mdl_errs    = '0;
      mdl_drops   = '0;
      mdl_len_err = 1'b0;
      exp_beats.delete();
   endfunction

   // Frame-level view: collect bytes after a sync and decide on each arrival
   // what the frame so far implies for the outgoing stream and the counters.
   function automatic void model_byte(input logic [7:0] b);
      logic [7:0] len;
      logic [7:0] x;
      bit         bad;
      if (mdl_hunting) begin
         if (b == DEFAULT_SYNC_BYTE) begin
            mdl_hunting = 1'b0;
            mdl_buf.delete();
         end else begin
            mdl_drops++;
         end
      end else begin
         mdl_buf.push_back(b);
         len = mdl_buf[0];
         if (mdl_buf.size() == 1) begin
            if (len == 0 || len > MAXL) begin
               mdl_len_err = 1'b1;
               mdl_errs++;
               mdl_hunting = 1'b1;
            end
         end else if (mdl_buf.size() <= int'(len)) begin
            exp_beats.push_back({1'b0, 1'b0, mdl_buf.size() == 2, b});
         end else if (mdl_buf.size() == int'(len) + 2) begin
            x = 8'h00;
            for (int i = 0; i <= int'(len); i++) x ^= mdl_buf[i];
            bad = (x != b);
            exp_beats.push_back({bad, 1'b1, len == 8'd1, mdl_buf[len]});
            if (bad) mdl_errs++;
            else     mdl_frames++;
            mdl_hunting = 1'b1;
         end
      end
   endfunction

   // One clock: compare at the falling edge, then apply the pop and the model
   // update just after the rising edge.
   task automatic step();
      logic        rst_s;
      logic        rd_s;
      logic        rdy_s;
      logic [10:0] beat;
      @(negedge clk_read);
      rst_s = rst_n;
      rd_s  = fifo_read;
      rdy_s = m_ready;
      beat  = {m_err, m_eop, m_sop, m_data};
      check("read_when_empty", rd_s && fifo_empty, 0);
      if (!rst_s) check("read_in_reset", rd_s, 0);
      check("drop_count", drop_count, mdl_drops);
      check("err_count", err_count, mdl_errs);
      check("frame_count", frame_count, mdl_frames);
      check("len_err", len_err, mdl_len_err);
      if (len_err) len_err_seen++;
      if (prev_hold) begin
         check("hold_valid", m_valid, 1);
         check("hold_beat", beat, prev_beat);
      end
      if (m_valid && rdy_s && rst_s) begin
         got_beats.push_back(beat);
         if (exp_beats.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat: got %0h expected none", beat);
         end else begin
            check("beat", beat, exp_beats.pop_front());
         end
      end
      prev_hold = m_valid && !rdy_s && rst_s;
      prev_beat = beat;
      @(posedge clk_read);
      #1;
      mdl_len_err = 1'b0;
      if (!rst_s) begin
         model_reset();
         prev_hold = 1'b0;
      end else if (rd_s && fq.size() != 0) begin
         pop_total++;
         model_byte(fq.pop_front());
      end
      drive_fifo();
   endtask

   task automatic reset_and_check();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_sop", m_sop, 0);
      check("rst_m_eop", m_eop, 0);
      check("rst_m_err", m_err, 0);
      check("rst_m_data", m_data, 0);
      check("rst_len_err", len_err, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_err_count", err_count, 0);
      check("rst_drop_count", drop_count, 0);
      got_beats.delete();
      len_err_seen = 0;
      pop_total = 0;
   endtask

   task automatic run_idle(input string name, input int budget);
      int n;
      n = 0;
      while (!(fq.size() == 0 && exp_beats.size() == 0 && !m_valid) && n < budget) begin
         step();
         n++;
      end
      n_checks++;
      if (n >= budget) begin
         n_errors++;
         $display("FAIL %s_timeout: got %0d cycles expected under %0d", name, n, budget);
      end
   endtask

   function automatic logic [10:0] got_at(input int i);
      return (got_beats.size() > i) ? got_beats[i] : 11'h7ff;
   endfunction

   initial begin
      int n;
      int p0;

      // basic frame, CHK = 03^11^22^33 = 03
      reset_and_check();
      fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      drive_fifo();
      run_idle("t1", 50);
      check("t1_beats", got_beats.size(), 3);
      check("t1_b0", got_at(0), 11'h111);
      check("t1_b1", got_at(1), 11'h022);
      check("t1_b2", got_at(2), 11'h233);
      check("t1_frames", frame_count, 1);
      check("t1_drops", drop_count, 0);
      check("t1_pops", pop_total, 6);

      // leading garbage, LEN=1
      reset_and_check();
      fq = '{8'h00, 8'h7F, 8'hA5, 8'h01, 8'h5A, 8'h5B};
      drive_fifo();
      run_idle("t2", 50);
      check("t2_drops", drop_count, 2);
      check("t2_beats", got_beats.size(), 1);
      check("t2_b0", got_at(0), 11'h35A);
      check("t2_frames", frame_count, 1);

      // bad checksum
      reset_and_check();
      fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'hFF};
      drive_fifo();
      run_idle("t3", 50);
      check("t3_b0", got_at(0), 11'h111);
      check("t3_b2", got_at(2), 11'h633);
      check("t3_errs", err_count, 1);
      check("t3_frames", frame_count, 0);

      // rejected lengths, then a good frame (CHK = 02^C1^C2 = 01)
      reset_and_check();
      fq = '{8'hA5, 8'h00, 8'hA5, 8'h41, 8'hA5, 8'h02, 8'hC1, 8'hC2, 8'h01};
      drive_fifo();
      run_idle("t4", 50);
      check("t4_len_err_pulses", len_err_seen, 2);
      check("t4_errs", err_count, 2);
      check("t4_frames", frame_count, 1);
      check("t4_b0", got_at(0), 11'h1C1);
      check("t4_b1", got_at(1), 11'h2C2);

      // backpressure and FIFO stall mid-payload, CHK = 08^01^..^08 = 00
      reset_and_check();
      fq = '{8'hA5, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
      drive_fifo();
      n = 0;
      while (!(m_valid && m_data == 8'h03) && n < 20) begin
         step();
         n++;
      end
      check("t5_reach_03", n < 20, 1);
      m_ready = 1'b0;
      p0 = pop_total;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t5_bp_data", m_data, 8'h03);
         check("t5_bp_valid", m_valid, 1);
      end
      check("t5_bp_pops", pop_total - p0, 0);
      m_ready = 1'b1;
      step();
      step();
      hold_empty = 1'b1;
      drive_fifo();
      p0 = pop_total;
      for (int i = 0; i < 3; i++) step();
      check("t5_stall_pops", pop_total - p0, 0);
      hold_empty = 1'b0;
      drive_fifo();
      run_idle("t5", 60);
      check("t5_beats", got_beats.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check("t5_order", got_at(i), {1'b0, i == 7, i == 0, 8'(i + 1)});
      end
      check("t5_frames", frame_count, 1);

      // reset right after the LEN pop; the rest of that frame is hunted over
      reset_and_check();
      fq = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44, 8'hA5, 8'h01, 8'h77, 8'h76};
      drive_fifo();
      step();
      step();
      reset_and_check();
      run_idle("t6", 60);
      check("t6_drops", drop_count, 5);
      check("t6_frames", frame_count, 1);
      check("t6_beats", got_beats.size(), 1);
      check("t6_b0", got_at(0), 11'h377);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
